// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between fetch and load/store requesters, data first,
// with a starvation guard for fetch. Optional perf counters: UNIFIED_MEM_ARB_PERF_EN.
module unified_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [DATA_W/8-1:0]   d_be_i,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_W-1:0]     d_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
`ifdef UNIFIED_MEM_ARB_PERF_EN
    output logic [31:0]           conflict_cnt_o,
    output logic [31:0]           forced_cnt_o,
`endif
    input  logic [DATA_W-1:0]     mem_rdata_i
);
    localparam int BE_W = DATA_W / 8;
    localparam int TAIL = MEM_LAT - 1;
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [MEM_LAT-1:0] vld_q, vld_d;
    logic [MEM_LAT-1:0] own_q, own_d;   // 1 = data requester
    logic               force_fetch;

    // Requests are masked while reset is held so nothing leaks to memory.
    always_comb begin
        force_fetch = reset_i && if_req_i && (wait_cnt_q == MAX_WAIT_C);
        if_gnt_o    = force_fetch || (reset_i && if_req_i && !d_req_i);
        d_gnt_o     = reset_i && d_req_i && !force_fetch;

        if (if_req_i && !if_gnt_o)
            wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 4'd1;
        else
            wait_cnt_d = 4'd0;
    end

    always_comb begin
        mem_req_o   = if_gnt_o || d_gnt_o;
        mem_we_o    = d_gnt_o && d_we_i;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (if_gnt_o) begin
            mem_be_o   = {BE_W{1'b1}};
            mem_addr_o = if_addr_i;
        end else if (d_gnt_o) begin
            mem_be_o    = d_be_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end
    end

    // Stores push an invalid slot so the tail stays aligned with the memory latency.
    always_comb begin
        vld_d    = '0;
        own_d    = '0;
        vld_d[0] = if_gnt_o || (d_gnt_o && !d_we_i);
        own_d[0] = d_gnt_o;
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
    end

    always_comb begin
        if_rvalid_o = vld_q[TAIL] && !own_q[TAIL];
        d_rvalid_o  = vld_q[TAIL] && own_q[TAIL];
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wait_cnt_q <= 4'd0;
            vld_q      <= '0;
            own_q      <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            vld_q      <= vld_d;
            own_q      <= own_d;
        end
    end

`ifdef UNIFIED_MEM_ARB_PERF_EN
    logic [31:0] conflict_cnt_q, conflict_cnt_d;
    logic [31:0] forced_cnt_q, forced_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q + {31'd0, (if_req_i && d_req_i)};
        forced_cnt_d   = forced_cnt_q + {31'd0, force_fetch};
        conflict_cnt_o = conflict_cnt_q;
        forced_cnt_o   = forced_cnt_q;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            conflict_cnt_q <= 32'd0;
            forced_cnt_q   <= 32'd0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            forced_cnt_q   <= forced_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=2,
// each backed by its own small behavioural memory.
module tb_unified_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_i;
    logic        if_req_i, d_req_i, d_we_i;
    logic [31:0] if_addr_i, d_addr_i, d_wdata_i;
    logic [3:0]  d_be_i;

    logic        if_gnt_1, if_rv_1, d_gnt_1, d_rv_1, mreq_1, mwe_1;
    logic [31:0] if_rd_1, d_rd_1, maddr_1, mwd_1, mrd_1;
    logic [3:0]  mbe_1;
    logic        if_gnt_2, if_rv_2, d_gnt_2, d_rv_2, mreq_2, mwe_2;
    logic [31:0] if_rd_2, d_rd_2, maddr_2, mwd_2, mrd_2;
    logic [3:0]  mbe_2;
`ifdef UNIFIED_MEM_ARB_PERF_EN
    logic [31:0] conf_1, forc_1, conf_2, forc_2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.MEM_LAT(1), .MAX_WAIT(3)) u1 (
        .clk_i(clk), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_1),
        .if_rvalid_o(if_rv_1), .if_rdata_o(if_rd_1),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_1), .d_rvalid_o(d_rv_1), .d_rdata_o(d_rd_1),
        .mem_req_o(mreq_1), .mem_we_o(mwe_1), .mem_be_o(mbe_1), .mem_addr_o(maddr_1),
        .mem_wdata_o(mwd_1),
`ifdef UNIFIED_MEM_ARB_PERF_EN
        .conflict_cnt_o(conf_1), .forced_cnt_o(forc_1),
`endif
        .mem_rdata_i(mrd_1));

    unified_mem_arbiter #(.MEM_LAT(2), .MAX_WAIT(3)) u2 (
        .clk_i(clk), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_2),
        .if_rvalid_o(if_rv_2), .if_rdata_o(if_rd_2),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_2), .d_rvalid_o(d_rv_2), .d_rdata_o(d_rd_2),
        .mem_req_o(mreq_2), .mem_we_o(mwe_2), .mem_be_o(mbe_2), .mem_addr_o(maddr_2),
        .mem_wdata_o(mwd_2),
`ifdef UNIFIED_MEM_ARB_PERF_EN
        .conflict_cnt_o(conf_2), .forced_cnt_o(forc_2),
`endif
        .mem_rdata_i(mrd_2));

    // Word-addressed memories, 64 words each, fixed read latency 1 and 2.
    logic [31:0] mem1 [0:63];
    logic [31:0] mem2 [0:63];
    logic [31:0] rp1, rp2a, rp2b;

    always @(posedge clk) begin
        if (mreq_1 && mwe_1)
            for (int b = 0; b < 4; b++)
                if (mbe_1[b]) mem1[maddr_1[7:2]][b*8 +: 8] <= mwd_1[b*8 +: 8];
        rp1 <= (mreq_1 && !mwe_1) ? mem1[maddr_1[7:2]] : 32'd0;
    end
    always @(posedge clk) begin
        if (mreq_2 && mwe_2)
            for (int b = 0; b < 4; b++)
                if (mbe_2[b]) mem2[maddr_2[7:2]][b*8 +: 8] <= mwd_2[b*8 +: 8];
        rp2a <= (mreq_2 && !mwe_2) ? mem2[maddr_2[7:2]] : 32'd0;
        rp2b <= rp2a;
    end
    assign mrd_1 = rp1;
    assign mrd_2 = rp2b;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0;
        d_be_i = 0; d_addr_i = 0; d_wdata_i = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd);
        idle();
        d_req_i = 1; d_we_i = 1; d_be_i = 4'hF; d_addr_i = a; d_wdata_i = wd;
    endtask

    task automatic test_reset();
        idle();
        reset_i = 0; if_req_i = 1; d_req_i = 1;
        #2;
        checks++; if ({if_gnt_1, d_gnt_1, mreq_1, if_rv_1, d_rv_1} !== 5'd0) begin errors++; $display("FAIL reset_ctrl_1 got %b exp 00000", {if_gnt_1, d_gnt_1, mreq_1, if_rv_1, d_rv_1}); end
        checks++; if ({if_gnt_2, d_gnt_2, mreq_2, if_rv_2, d_rv_2} !== 5'd0) begin errors++; $display("FAIL reset_ctrl_2 got %b exp 00000", {if_gnt_2, d_gnt_2, mreq_2, if_rv_2, d_rv_2}); end
        checks++; if ({maddr_1, mwd_1, mbe_1, if_rd_1, d_rd_1} !== 132'd0) begin errors++; $display("FAIL reset_data_1 got %h exp 0", {maddr_1, mwd_1, mbe_1, if_rd_1, d_rd_1}); end
        step(); step();
        idle(); reset_i = 1;
    endtask

    task automatic test_fetch_only();
        step(); store(32'h10, 32'h0050_0093);
        step(); idle(); if_req_i = 1; if_addr_i = 32'h10;
        #1;
        checks++; if ({if_gnt_1, d_gnt_1} !== 2'b10) begin errors++; $display("FAIL fetch_gnt got %b exp 10", {if_gnt_1, d_gnt_1}); end
        checks++; if ({mreq_1, mwe_1, mbe_1, maddr_1} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin errors++; $display("FAIL fetch_mem got %b %b %h %h exp 1 0 f 10", mreq_1, mwe_1, mbe_1, maddr_1); end
        step(); idle();
        #1;
        checks++; if ({if_rv_1, if_rd_1} !== {1'b1, 32'h0050_0093}) begin errors++; $display("FAIL fetch_rv_lat1 got %b %h exp 1 00500093", if_rv_1, if_rd_1); end
        checks++; if ({d_rv_1, d_rd_1} !== 33'd0) begin errors++; $display("FAIL fetch_no_d_1 got %b %h exp 0 0", d_rv_1, d_rd_1); end
        checks++; if (if_rv_2 !== 1'b0) begin errors++; $display("FAIL fetch_early_lat2 got %b exp 0", if_rv_2); end
        step();
        #1;
        checks++; if ({if_rv_2, if_rd_2} !== {1'b1, 32'h0050_0093}) begin errors++; $display("FAIL fetch_rv_lat2 got %b %h exp 1 00500093", if_rv_2, if_rd_2); end
        checks++; if (if_rv_1 !== 1'b0) begin errors++; $display("FAIL fetch_rv_once got %b exp 0", if_rv_1); end
    endtask

    task automatic test_store_priority();
        step(); store(32'd100, 32'd25); if_req_i = 1; if_addr_i = 32'h10;
        #1;
        checks++; if ({d_gnt_1, if_gnt_1} !== 2'b10) begin errors++; $display("FAIL st_gnt got %b exp 10", {d_gnt_1, if_gnt_1}); end
        checks++; if ({mwe_1, maddr_1, mwd_1, mbe_1} !== {1'b1, 32'd100, 32'd25, 4'hF}) begin errors++; $display("FAIL st_mem got %b %0d %0d %h exp 1 100 25 f", mwe_1, maddr_1, mwd_1, mbe_1); end
        step(); idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if ({d_rv_1, d_rv_2, if_rv_1, if_rv_2} !== 4'd0) begin errors++; $display("FAIL st_no_rvalid c%0d got %b exp 0000", c, {d_rv_1, d_rv_2, if_rv_1, if_rv_2}); end
            step();
        end
    endtask

    task automatic test_starvation();
        logic [4:0] exp_d;
        exp_d = 5'b10111;
        idle(); reset_i = 0; step(); reset_i = 1;
        for (int c = 0; c < 5; c++) begin
            step(); store(32'd200, 32'(c)); if_req_i = 1; if_addr_i = 32'h10;
            #1;
            checks++; if ({if_gnt_1, d_gnt_1} !== {~exp_d[c], exp_d[c]}) begin errors++; $display("FAIL starve_c%0d got if=%b d=%b exp if=%b d=%b", c, if_gnt_1, d_gnt_1, ~exp_d[c], exp_d[c]); end
            checks++; if ({if_gnt_2, d_gnt_2} !== {~exp_d[c], exp_d[c]}) begin errors++; $display("FAIL starve2_c%0d got if=%b d=%b", c, if_gnt_2, d_gnt_2); end
        end
        step(); idle();
`ifdef UNIFIED_MEM_ARB_PERF_EN
        #1;
        checks++; if ({conf_1, forc_1} !== {32'd5, 32'd1}) begin errors++; $display("FAIL perf_cnt got conflict=%0d forced=%0d exp 5 1", conf_1, forc_1); end
`endif
        step(); step();
    endtask

    task automatic test_interleaved();
        step(); store(32'h20, 32'hAA);
        step(); store(32'h24, 32'hBB);
        step(); idle(); if_req_i = 1; if_addr_i = 32'h20;
        step(); idle(); d_req_i = 1; d_addr_i = 32'h24; d_be_i = 4'hF;
        #1;
        checks++; if ({d_gnt_1, if_rv_1, if_rd_1} !== {1'b1, 1'b1, 32'hAA}) begin errors++; $display("FAIL il_c1 got gnt=%b rv=%b %h exp 1 1 aa", d_gnt_1, if_rv_1, if_rd_1); end
        step(); idle();
        #1;
        checks++; if ({if_rv_2, if_rd_2, d_rv_2, d_rd_2} !== {1'b1, 32'hAA, 1'b0, 32'd0}) begin errors++; $display("FAIL il_c2_lat2 got if=%b %h d=%b %h exp 1 aa 0 0", if_rv_2, if_rd_2, d_rv_2, d_rd_2); end
        checks++; if ({d_rv_1, d_rd_1, if_rv_1, if_rd_1} !== {1'b1, 32'hBB, 1'b0, 32'd0}) begin errors++; $display("FAIL il_c2_lat1 got d=%b %h if=%b %h exp 1 bb 0 0", d_rv_1, d_rd_1, if_rv_1, if_rd_1); end
        step();
        #1;
        checks++; if ({d_rv_2, d_rd_2, if_rv_2, if_rd_2} !== {1'b1, 32'hBB, 1'b0, 32'd0}) begin errors++; $display("FAIL il_c3_lat2 got d=%b %h if=%b %h exp 1 bb 0 0", d_rv_2, d_rd_2, if_rv_2, if_rd_2); end
    endtask

    task automatic test_reset_midflight();
        step(); idle(); d_req_i = 1; d_addr_i = 32'h24; d_be_i = 4'hF; if_req_i = 1;
        #1;
        checks++; if (d_gnt_1 !== 1'b1) begin errors++; $display("FAIL rmf_gnt got %b exp 1", d_gnt_1); end
        #1; reset_i = 0;
        #1;
        checks++; if ({d_gnt_1, if_gnt_1, mreq_1, mwe_1, maddr_1, mbe_1} !== 40'd0) begin errors++; $display("FAIL rmf_outs got %h exp 0", {d_gnt_1, if_gnt_1, mreq_1, mwe_1, maddr_1, mbe_1}); end
        step(); step(); idle(); reset_i = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if ({d_rv_1, d_rv_2, if_rv_1, if_rv_2} !== 4'd0) begin errors++; $display("FAIL rmf_no_rv c%0d got %b exp 0000", c, {d_rv_1, d_rv_2, if_rv_1, if_rv_2}); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        step(); store(32'd96, 32'd7);
        #1;
        checks++; if ({d_gnt_1, mwe_1} !== 2'b11) begin errors++; $display("FAIL b2b_store got %b exp 11", {d_gnt_1, mwe_1}); end
        step(); idle(); d_req_i = 1; d_addr_i = 32'd96; d_be_i = 4'hF;
        #1;
        checks++; if ({d_gnt_1, mwe_1, maddr_1} !== {1'b1, 1'b0, 32'd96}) begin errors++; $display("FAIL b2b_load got %b %b %0d exp 1 0 96", d_gnt_1, mwe_1, maddr_1); end
        step(); idle();
        #1;
        checks++; if ({d_rv_1, d_rd_1} !== {1'b1, 32'd7}) begin errors++; $display("FAIL b2b_rd_lat1 got %b %0d exp 1 7", d_rv_1, d_rd_1); end
        step();
        #1;
        checks++; if ({d_rv_2, d_rd_2} !== {1'b1, 32'd7}) begin errors++; $display("FAIL b2b_rd_lat2 got %b %0d exp 1 7", d_rv_2, d_rd_2); end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_store_priority();
        test_starvation();
        test_interleaved();
        test_reset_midflight();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
